updown_burst_sched: RTL and testbench
=====================================

// Module: updown_burst_sched
// PURPOSE
//  Shares one WIDTH-bit up/down count register among NUM_REQ requesters.
//  Each requester asks for a burst of LEN steps in one direction (inst 0 = up, 1 = down).
//  A round-robin arbiter grants one burst at a time; an FSM steps the register once per cycle.
//  Sits between the software-visible command queues and the counter datapath it owns.
// PARAMETERS
//  NUM_REQ  4   number of requesters (>=2)
//  WIDTH    32  count register width
//  LEN_W    8   burst length field width; max burst = 2^LEN_W-1
// PORTS
//  clock      in   1              single clock, rising edge
//  reset      in   1              asynchronous, active-low; clears all state
//  req_valid  in   NUM_REQ        burst request per requester
//  req_inst   in   NUM_REQ        direction per requester: 0 up, 1 down
//  req_len    in   NUM_REQ*LEN_W  burst length; requester i uses bits [i*LEN_W +: LEN_W]
//  req_ready  out  NUM_REQ        one-hot accept pulse; handshake = valid & ready
//  done       out  NUM_REQ        one-cycle pulse to owner when its burst completes
//  clr        in   1              synchronous clear of value to 0
//  busy       out  1              high in RUN or DONE
//  owner      out  $clog2(NUM_REQ) index of current/last granted requester
//  value      out  WIDTH          current count register
//  sat        out  1              sticky saturation flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset values: value=0, state=IDLE, rr pointer=0, owner=0, req_ready=0, done=0, busy=0, sat=0.
//  FSM: IDLE -> RUN (accept, len>0); IDLE -> DONE (accept, len==0); RUN -> DONE after last step;
//       DONE -> IDLE unconditionally.
//  IDLE: arbitrate among req_valid starting at rr pointer; req_ready[g]=1 combinationally that cycle.
//       Latch inst, len, owner=g; rr pointer <= g+1 mod NUM_REQ.
//  RUN: each cycle value <= value +/- 1, remaining <= remaining-1; leave when remaining==1.
//  Latency: accept at cycle t -> first value change at edge ending t+1 -> done[owner] high
//       in cycle t+len+1 -> next accept possible in cycle t+len+2.
//  Requesters hold valid, inst and len stable until ready. Dropping valid early is illegal; no check is made.
//  Arbitration happens only in IDLE; req_ready is all-zero in RUN and DONE.
//  Arithmetic: modulo 2^WIDTH; 0-1 wraps to all-ones; all-ones+1 wraps to 0.
//  clr: value<=0 in any state; takes priority over that cycle's step.
//       The burst is not aborted; remaining steps continue from 0. sat is not cleared.
//  Reset asserted mid-burst: immediate return to reset values; no done pulse is issued.
//  len==0: counts as a legal burst, no steps, done still pulses (cycle t+1).
// CONFIGURATION
//  Macro UPDOWN_SCHED_SAT_EN:
//   defined: stepping saturates at 0 (down) and 2^WIDTH-1 (up).
//            Blocked steps still consume len. Any blocked step sets sat; only reset clears sat.
//   undefined: modulo wrap as above; sat tied to 0.
// STRUCTURE
//  Package updown_sched_pkg: state enum {IDLE,RUN,DONE}; localparam INST_UP=1'b0, INST_DOWN=1'b1.
//  Sub-module rr_arbiter #(NUM_REQ): inputs req, ptr; outputs grant one-hot, grant_idx, any.
//       Purely combinational; the pointer register lives in updown_burst_sched.
//  FSM, remaining counter and value register stay in the top module.
// TESTING
//  1. reset low, then req0 up len=5 -> ready[0] cycle t; value 0..5 over 5 cycles; done[0] at t+6.
//  2. value=0, req1 down len=1 -> value=32'hFFFF_FFFF, sat=0
//     (with UPDOWN_SCHED_SAT_EN: value=0, sat=1).
//  3. all 4 valid continuously, len=2 each -> grant order 0,1,2,3,0; each grant 4 cycles apart.
//  4. req2 up len=10; assert clr at step 4 -> value 0 then 1..6; done[2] on schedule.
//  5. req3 len=0 -> ready[3] then done[3] next cycle; value unchanged; busy high 1 cycle.
//  6. reset pulsed low mid-burst (step 3 of 8) -> value=0, IDLE, no done; pending req re-granted after reset.

Source files
------------

// File: rtl/updown_sched_pkg.sv
// Shared types for the up/down burst scheduler: FSM state encoding and burst direction codes.
package updown_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic INST_UP   = 1'b0;
  localparam logic INST_DOWN = 1'b1;

endpackage

// File: rtl/updown_burst_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr wins.
// The rotating pointer register is owned by the instantiating module.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       any
);

  localparam int IW = $clog2(NUM_REQ);

  always_comb begin
    int unsigned idx;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr) + k) % NUM_REQ;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/updown_burst_sched.sv
// Shares one up/down count register among NUM_REQ burst requesters via round-robin grants.
// Define UPDOWN_SCHED_SAT_EN to saturate at 0 / all-ones instead of wrapping (sets sticky sat).
module updown_burst_sched
  import updown_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int LEN_W   = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_inst,
  input  logic [NUM_REQ*LEN_W-1:0]   req_len,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         done,
  input  logic                       clr,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic [WIDTH-1:0]           value,
  output logic                       sat
);

  localparam int IW = $clog2(NUM_REQ);

  state_t             state, state_nx;
  logic [IW-1:0]      rr_ptr, grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic               any_req, accept, inst_q;
  logic [LEN_W-1:0]   rem, len_sel;
  logic [WIDTH-1:0]   stepped;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req      (req_valid),
    .ptr      (rr_ptr),
    .grant    (grant),
    .grant_idx(grant_idx),
    .any      (any_req)
  );

  always_comb begin
    len_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++)
      if (grant_idx == IW'(i)) len_sel = req_len[i*LEN_W +: LEN_W];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // reset gates the accept so req_ready stays low while reset is held
  always_comb begin
    state_nx  = state;
    req_ready = '0;
    done      = '0;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_req && reset) begin
          accept    = 1'b1;
          req_ready = grant;
          state_nx  = (len_sel == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (rem == LEN_W'(1)) state_nx = DONE;
      end
      DONE: begin
        done[owner] = 1'b1;
        state_nx    = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

`ifdef UPDOWN_SCHED_SAT_EN
  logic blocked, sat_q;

  assign blocked = (inst_q == INST_DOWN) ? (value == '0) : (value == '1);

  always_comb begin
    if (blocked)                 stepped = value;
    else if (inst_q == INST_DOWN) stepped = value - WIDTH'(1);
    else                          stepped = value + WIDTH'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                              sat_q <= 1'b0;
    else if (state == RUN && !clr && blocked) sat_q <= 1'b1;
  end

  assign sat = sat_q;
`else
  always_comb begin
    stepped = (inst_q == INST_DOWN) ? value - WIDTH'(1) : value + WIDTH'(1);
  end

  assign sat = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
      owner  <= '0;
      inst_q <= INST_UP;
      rem    <= '0;
      value  <= '0;
    end else begin
      if (accept) begin
        owner  <= grant_idx;
        inst_q <= req_inst[grant_idx];
        rem    <= len_sel;
        rr_ptr <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + IW'(1);
      end
      if (state == RUN) rem <= rem - LEN_W'(1);
      // clr wins over the step but leaves the burst running
      if (clr)                value <= '0;
      else if (state == RUN)  value <= stepped;
    end
  end

endmodule

// File: tb/tb_updown_burst_sched.sv
// Directed self-checking bench for updown_burst_sched (default and UPDOWN_SCHED_SAT_EN builds).
module tb_updown_burst_sched;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 32;
  localparam int LEN_W   = 8;
`ifdef UPDOWN_SCHED_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic                     clock = 1'b0;
  logic                     reset = 1'b0;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ-1:0]       req_inst = '0;
  logic [NUM_REQ*LEN_W-1:0] req_len = '0;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       done;
  logic                     clr = 1'b0;
  logic                     busy;
  logic [1:0]               owner;
  logic [WIDTH-1:0]         value;
  logic                     sat;

  int checks   = 0;
  int failures = 0;

  updown_burst_sched #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clock    (clock),
    .reset    (reset),
    .req_valid(req_valid),
    .req_inst (req_inst),
    .req_len  (req_len),
    .req_ready(req_ready),
    .done     (done),
    .clr      (clr),
    .busy     (busy),
    .owner    (owner),
    .value    (value),
    .sat      (sat)
  );

  always #5 clock = ~clock;

  // Advance to just after the next rising edge; inputs are driven here, checks follow a further #1.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cyc();
    cyc();
    #1;
    checks++; if (value !== '0)     begin failures++; $display("FAIL rst_value got=%h exp=0", value); end
    checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (req_ready !== '0) begin failures++; $display("FAIL rst_ready got=%b exp=0000", req_ready); end
    checks++; if (done !== '0)      begin failures++; $display("FAIL rst_done got=%b exp=0000", done); end
    checks++; if (owner !== 2'd0)   begin failures++; $display("FAIL rst_owner got=%0d exp=0", owner); end
    checks++; if (sat !== 1'b0)     begin failures++; $display("FAIL rst_sat got=%b exp=0", sat); end
    reset = 1'b1;
  endtask

  // req0 up len=5 accepted in cycle t; value 1..5 over t+2..t+6; done[0] in t+6
  task automatic test_up_burst();
    logic [WIDTH-1:0]   exp_v;
    logic [NUM_REQ-1:0] exp_d;
    req_valid = 4'b0001;
    req_inst  = 4'b0000;
    req_len   = '0;
    req_len[7:0] = 8'd5;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL up_ready got=%b exp=0001", req_ready); end
    checks++; if (busy !== 1'b0)         begin failures++; $display("FAIL up_busy_idle got=%b exp=0", busy); end
    for (int c = 1; c <= 7; c++) begin
      cyc();
      if (c == 1) req_valid = '0;
      #1;
      exp_v = (c <= 6) ? WIDTH'(c - 1) : WIDTH'(5);
      exp_d = (c == 6) ? 4'b0001 : 4'b0000;
      checks++; if (value !== exp_v) begin failures++; $display("FAIL up_value c=%0d got=%0d exp=%0d", c, value, exp_v); end
      checks++; if (done !== exp_d)  begin failures++; $display("FAIL up_done c=%0d got=%b exp=%b", c, done, exp_d); end
      checks++; if (busy !== (c <= 6)) begin failures++; $display("FAIL up_busy c=%0d got=%b exp=%b", c, busy, (c <= 6)); end
    end
  endtask

  // clear to 0 then req1 down len=1: wraps to all-ones, or holds 0 and sets sat
  task automatic test_down_wrap();
    logic [WIDTH-1:0] exp_v;
    exp_v = SAT ? '0 : '1;
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    req_valid = 4'b0010;
    req_inst  = 4'b0010;
    req_len   = '0;
    req_len[15:8] = 8'd1;
    #1;
    checks++; if (value !== '0)          begin failures++; $display("FAIL dn_clr got=%h exp=0", value); end
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL dn_ready got=%b exp=0010", req_ready); end
    cyc();
    req_valid = '0;
    cyc();
    #1;
    checks++; if (value !== exp_v)     begin failures++; $display("FAIL dn_value got=%h exp=%h", value, exp_v); end
    checks++; if (sat !== SAT)         begin failures++; $display("FAIL dn_sat got=%b exp=%b", sat, SAT); end
    checks++; if (done !== 4'b0010)    begin failures++; $display("FAIL dn_done got=%b exp=0010", done); end
    checks++; if (owner !== 2'd1)      begin failures++; $display("FAIL dn_owner got=%0d exp=1", owner); end
    cyc();
    #1;
    checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL dn_idle got=%b exp=0", busy); end
  endtask

  // fresh reset, all four valid with len=2: grants 0,1,2,3,0 four cycles apart
  task automatic test_back_to_back();
    logic [NUM_REQ-1:0] exp_g;
    int cyc_n  = 0;
    int last   = 0;
    int gcount = 0;
    reset = 1'b0;
    #1;
    cyc();
    reset = 1'b1;
    req_valid = 4'b1111;
    req_inst  = 4'b0000;
    req_len   = {4{8'd2}};
    while (gcount < 5 && cyc_n < 40) begin
      #1;
      if (req_ready !== 4'b0000) begin
        exp_g = 4'b0001 << (gcount % 4);
        checks++; if (req_ready !== exp_g) begin failures++; $display("FAIL rr_grant n=%0d got=%b exp=%b", gcount, req_ready, exp_g); end
        if (gcount > 0) begin
          checks++; if (cyc_n - last != 4) begin failures++; $display("FAIL rr_spacing n=%0d got=%0d exp=4", gcount, cyc_n - last); end
        end
        last = cyc_n;
        gcount++;
      end
      if (gcount < 5) begin
        cyc();
        cyc_n++;
      end
    end
    checks++; if (gcount != 5) begin failures++; $display("FAIL rr_timeout got=%0d exp=5 grants", gcount); end
    cyc();
    req_valid = '0;
    cyc();
    cyc();
    #1;
    checks++; if (value !== WIDTH'(10)) begin failures++; $display("FAIL rr_value got=%0d exp=10", value); end
    checks++; if (done !== 4'b0001)     begin failures++; $display("FAIL rr_done got=%b exp=0001", done); end
    cyc();
  endtask

  // req2 up len=10 from value 10; clr in place of step 4 -> 0 then 1..6
  task automatic test_clr_mid_burst();
    logic [WIDTH-1:0]   exp_v;
    logic [NUM_REQ-1:0] exp_d;
    req_valid = 4'b0100;
    req_inst  = 4'b0000;
    req_len   = '0;
    req_len[23:16] = 8'd10;
    #1;
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL clr_ready got=%b exp=0100", req_ready); end
    for (int c = 1; c <= 12; c++) begin
      cyc();
      if (c == 1) req_valid = '0;
      clr = (c == 4);
      #1;
      if (c <= 4)       exp_v = WIDTH'(9 + c);
      else if (c == 5)  exp_v = '0;
      else if (c <= 11) exp_v = WIDTH'(c - 5);
      else              exp_v = WIDTH'(6);
      exp_d = (c == 11) ? 4'b0100 : 4'b0000;
      checks++; if (value !== exp_v) begin failures++; $display("FAIL clr_value c=%0d got=%0d exp=%0d", c, value, exp_v); end
      checks++; if (done !== exp_d)  begin failures++; $display("FAIL clr_done c=%0d got=%b exp=%b", c, done, exp_d); end
    end
    clr = 1'b0;
  endtask

  // req3 len=0: ready then done next cycle, value unchanged, busy for one cycle
  task automatic test_zero_len();
    req_valid = 4'b1000;
    req_inst  = 4'b0000;
    req_len   = '0;
    #1;
    checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL z_ready got=%b exp=1000", req_ready); end
    cyc();
    req_valid = '0;
    #1;
    checks++; if (done !== 4'b1000)     begin failures++; $display("FAIL z_done got=%b exp=1000", done); end
    checks++; if (busy !== 1'b1)        begin failures++; $display("FAIL z_busy got=%b exp=1", busy); end
    checks++; if (value !== WIDTH'(6))  begin failures++; $display("FAIL z_value got=%0d exp=6", value); end
    cyc();
    #1;
    checks++; if (busy !== 1'b0)        begin failures++; $display("FAIL z_idle got=%b exp=0", busy); end
    checks++; if (done !== 4'b0000)     begin failures++; $display("FAIL z_done_clear got=%b exp=0000", done); end
  endtask

  // req0 up len=8 aborted by reset after 3 steps; pending req1 (down len=2) granted after release
  task automatic test_reset_mid_burst();
    logic [WIDTH-1:0] exp_v;
    req_valid = 4'b0011;
    req_inst  = 4'b0010;
    req_len   = '0;
    req_len[7:0]  = 8'd8;
    req_len[15:8] = 8'd2;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL rm_ready0 got=%b exp=0001", req_ready); end
    for (int c = 1; c <= 4; c++) begin
      cyc();
      if (c == 1) req_valid = 4'b0010;
      #1;
      checks++; if (value !== WIDTH'(5 + c)) begin failures++; $display("FAIL rm_value c=%0d got=%0d exp=%0d", c, value, 5 + c); end
    end
    reset = 1'b0;
    #1;
    checks++; if (value !== '0)          begin failures++; $display("FAIL rm_rst_value got=%h exp=0", value); end
    checks++; if (busy !== 1'b0)         begin failures++; $display("FAIL rm_rst_busy got=%b exp=0", busy); end
    checks++; if (done !== 4'b0000)      begin failures++; $display("FAIL rm_rst_done got=%b exp=0000", done); end
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL rm_rst_ready got=%b exp=0000", req_ready); end
    checks++; if (owner !== 2'd0)        begin failures++; $display("FAIL rm_rst_owner got=%0d exp=0", owner); end
    checks++; if (sat !== 1'b0)          begin failures++; $display("FAIL rm_rst_sat got=%b exp=0", sat); end
    cyc();
    #1;
    checks++; if (done !== 4'b0000)      begin failures++; $display("FAIL rm_hold_done got=%b exp=0000", done); end
    reset = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL rm_regrant got=%b exp=0010", req_ready); end
    cyc();
    req_valid = '0;
    #1;
    checks++; if (busy !== 1'b1)         begin failures++; $display("FAIL rm_run_busy got=%b exp=1", busy); end
    cyc();
    #1;
    exp_v = SAT ? '0 : '1;
    checks++; if (value !== exp_v)       begin failures++; $display("FAIL rm_step1 got=%h exp=%h", value, exp_v); end
    cyc();
    #1;
    exp_v = SAT ? '0 : 32'hFFFF_FFFE;
    checks++; if (value !== exp_v)       begin failures++; $display("FAIL rm_step2 got=%h exp=%h", value, exp_v); end
    checks++; if (done !== 4'b0010)      begin failures++; $display("FAIL rm_done got=%b exp=0010", done); end
    checks++; if (sat !== SAT)           begin failures++; $display("FAIL rm_sat got=%b exp=%b", sat, SAT); end
  endtask

  initial begin
    test_reset();
    test_up_burst();
    test_down_wrap();
    test_back_to_back();
    test_clr_mid_burst();
    test_zero_len();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
